// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared types and constants for the gate response checker
package gate_chk_pkg;

  typedef enum logic [1:0] {
    F_AND  = 2'd0,
    F_OR   = 2'd1,
    F_XOR  = 2'd2,
    F_NAND = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  localparam logic [3:0] COV_ALL = 4'b1111;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden model of the two-input gate family
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  func_e func,
  input  logic  a,
  input  logic  b,
  output logic  exp
);

  always_comb begin
    exp = 1'b0;
    case (func)
      F_AND:   exp = a & b;
      F_OR:    exp = a | b;
      F_XOR:   exp = a ^ b;
      F_NAND:  exp = ~(a & b);
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - compares a gate's output against the selected reference
// function, tracking truth-table coverage and saturating pass/fail counts
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int FUNC_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FUNC_W-1:0] func_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a,
  input  logic              b,
  input  logic              y,
  output logic [3:0]        cov,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic [2:0]        first_fail,
  output logic              done,
  output logic              pass
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  func_e            func_q, func_d;
  logic [3:0]       cov_q, cov_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic [2:0]       first_fail_q, first_fail_d;

  logic exp_v;
  logic mismatch;

  gate_ref_model u_ref (
    .func (func_q),
    .a    (a),
    .b    (b),
    .exp  (exp_v)
  );

  // Case equality makes an unknown y count as a mismatch in simulation.
  assign mismatch = !(y === exp_v);

  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    cov_d        = cov_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;

    if (start) begin
      // start wins over any vector presented in the same cycle
      state_d      = S_CHECK;
      func_d       = func_e'(func_sel[1:0]);
      cov_d        = '0;
      pass_cnt_d   = '0;
      fail_cnt_d   = '0;
      err_d        = 1'b0;
      first_fail_d = '0;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (in_valid) begin
            if (mismatch) begin
              if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
              if (!err_q) begin
                err_d        = 1'b1;
                first_fail_d = {a, b, y};
              end
            end else begin
              if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
            cov_d[{a, b}] = 1'b1;
            if (cov_d == COV_ALL) state_d = S_REPORT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      func_q       <= F_AND;
      cov_q        <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      err_q        <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      cov_q        <= cov_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign in_ready   = (state_q == S_CHECK);
  assign done       = (state_q == S_REPORT);
  assign pass       = done && (fail_cnt_q == '0);
  assign cov        = cov_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign err        = err_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb/tb_gate_resp_checker.sv - randomized and directed bench against a transaction-level model
module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] func_sel;
  logic       in_valid;
  logic       a, b, y;

  logic       in_ready_w, in_ready_s;
  logic [3:0] cov_w, cov_s;
  logic [7:0] pass_cnt_w, fail_cnt_w;
  logic [1:0] pass_cnt_s, fail_cnt_s;
  logic       err_w, err_s, done_w, done_s, pass_w, pass_s;
  logic [2:0] first_fail_w, first_fail_s;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  bit         m_armed, m_reported, m_err;
  int         m_pass_n, m_fail_n;
  logic [3:0] m_cov;
  logic [2:0] m_first_fail;
  logic [1:0] m_func;

  always #5 clk = ~clk;

  gate_resp_checker #(.CNT_W(8), .FUNC_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel),
    .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b), .y(y),
    .cov(cov_w), .pass_cnt(pass_cnt_w), .fail_cnt(fail_cnt_w), .err(err_w),
    .first_fail(first_fail_w), .done(done_w), .pass(pass_w)
  );

  gate_resp_checker #(.CNT_W(2), .FUNC_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .y(y),
    .cov(cov_s), .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s), .err(err_s),
    .first_fail(first_fail_s), .done(done_s), .pass(pass_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  function automatic logic gate_fn(input logic [1:0] f, input logic aa, input logic bb);
    case (f)
      2'd0:    return aa & bb;
      2'd1:    return aa | bb;
      2'd2:    return aa ^ bb;
      default: return ~(aa & bb);
    endcase
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_reported = 0; m_err = 0;
    m_pass_n = 0; m_fail_n = 0; m_cov = '0; m_first_fail = '0; m_func = '0;
  endtask

  task automatic model_edge();
    if (start) begin
      m_armed = 1; m_reported = 0; m_err = 0;
      m_pass_n = 0; m_fail_n = 0; m_cov = '0; m_first_fail = '0;
      m_func = func_sel;
    end else if (m_armed && !m_reported && in_valid) begin
      if (y === gate_fn(m_func, a, b)) m_pass_n++;
      else begin
        m_fail_n++;
        if (!m_err) begin m_err = 1; m_first_fail = {a, b, y}; end
      end
      m_cov = m_cov | (4'b0001 << {a, b});
      if (m_cov == 4'b1111) m_reported = 1;
    end
  endtask

  task automatic check_all(input string ph);
    bit rdy = m_armed && !m_reported;
    bit pv  = m_reported && (m_fail_n == 0);
    check({ph, ".in_ready"},   {31'd0, in_ready_w}, {31'd0, rdy});
    check({ph, ".done"},       {31'd0, done_w},     {31'd0, m_reported});
    check({ph, ".pass"},       {31'd0, pass_w},     {31'd0, pv});
    check({ph, ".cov"},        {28'd0, cov_w},      {28'd0, m_cov});
    check({ph, ".pass_cnt"},   {24'd0, pass_cnt_w}, sat(m_pass_n, 8));
    check({ph, ".fail_cnt"},   {24'd0, fail_cnt_w}, sat(m_fail_n, 8));
    check({ph, ".err"},        {31'd0, err_w},      {31'd0, m_err});
    check({ph, ".first_fail"}, {29'd0, first_fail_w}, {29'd0, m_first_fail});
    check({ph, ".s.pass_cnt"}, {30'd0, pass_cnt_s}, sat(m_pass_n, 2));
    check({ph, ".s.fail_cnt"}, {30'd0, fail_cnt_s}, sat(m_fail_n, 2));
    check({ph, ".s.done"},     {31'd0, done_s},     {31'd0, m_reported});
    check({ph, ".s.pass"},     {31'd0, pass_s},     {31'd0, pv});
  endtask

  task automatic cyc(input string ph, input logic st, input logic [1:0] fs,
                     input logic v, input logic aa, input logic bb, input logic yy);
    start = st; func_sel = fs; in_valid = v; a = aa; b = bb; y = yy;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic vec(input string ph, input logic aa, input logic bb, input logic yy);
    cyc(ph, 1'b0, 2'd0, 1'b1, aa, bb, yy);
  endtask

  initial begin
    start = 0; func_sel = 0; in_valid = 0; a = 0; b = 0; y = 0;
    rst = 1;
    model_reset();
    #12;
    check_all("reset");
    rst = 0;
    cyc("idle_ignore", 0, 2'd0, 1, 1, 1, 1);

    // OR, correct gate
    cyc("start_or", 1, 2'd1, 0, 0, 0, 0);
    vec("or", 0, 0, 0); vec("or", 0, 1, 1); vec("or", 1, 0, 1); vec("or", 1, 1, 1);
    cyc("or_hold", 0, 2'd0, 1, 0, 0, 1);

    // OR, stuck-at-0 output
    cyc("start_sa0", 1, 2'd1, 0, 0, 0, 0);
    vec("sa0", 0, 0, 0); vec("sa0", 0, 1, 0); vec("sa0", 1, 0, 0); vec("sa0", 1, 1, 0);
    check("sa0.first_fail_lit", {29'd0, first_fail_w}, 32'd2);

    // XOR with repeats
    cyc("start_xor", 1, 2'd2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) vec("xor", 0, 0, 0);
    vec("xor", 0, 1, 1); vec("xor", 1, 0, 1); vec("xor", 1, 1, 0);
    check("xor.pass_cnt_lit", {24'd0, pass_cnt_w}, 32'd6);

    // restart mid-check with a vector in the same cycle
    cyc("start_and", 1, 2'd0, 0, 0, 0, 0);
    vec("and", 0, 0, 0); vec("and", 1, 1, 1);
    cyc("restart", 1, 2'd3, 1, 0, 1, 0);
    vec("nand", 0, 0, 1); vec("nand", 0, 1, 1); vec("nand", 1, 0, 1); vec("nand", 1, 1, 0);

    // saturation of the narrow instance
    cyc("start_sat", 1, 2'd1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) vec("sat", 0, 0, 0);
    vec("sat", 0, 1, 1); vec("sat", 1, 0, 1); vec("sat", 1, 1, 1);
    check("sat.s.pass_cnt_lit", {30'd0, pass_cnt_s}, 32'd3);

    // asynchronous reset in the middle of a check
    cyc("start_rst", 1, 2'd2, 0, 0, 0, 0);
    vec("pre_rst", 1, 1, 1);
    rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 0;
    check_all("post_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic st, v, aa, bb, yy;
      logic [1:0] fs;
      st = ($urandom_range(0, 29) == 0) || (m_reported && $urandom_range(0, 3) == 0)
           || (!m_armed);
      fs = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 3) != 0);
      aa = 1'($urandom_range(0, 1));
      bb = 1'($urandom_range(0, 1));
      yy = gate_fn(m_func, aa, bb) ^ ($urandom_range(0, 7) == 0);
      cyc("rand", st, fs, v, aa, bb, yy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
Response-side counterpart to the gate stimulus benches. It samples each applied two-input vector together with the gate output, compares the output against the selected reference function, and tracks truth-table coverage and pass/fail counts. When all four input combinations have been checked, it reports a final verdict. It sits beside a gate under test (the and/or family) and replaces manual $display inspection with a synthesizable checker.

Parameters:
CNT_W, 8, width of the pass and fail counters (saturating)
FUNC_W, 2, width of the function select: 0=AND, 1=OR, 2=XOR, 3=NAND

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that clears statistics and arms checking
func_sel  input  FUNC_W  reference function, captured on start
in_valid  input  1  a, b and y are valid this cycle
in_ready  output  1  checker accepts a vector this cycle
a  input  1  applied operand a
b  input  1  applied operand b
y  input  1  observed gate output
cov  output  4  coverage bitmap; bit index {a,b} is set once that combination has been checked
pass_cnt  output  CNT_W  count of matching vectors
fail_cnt  output  CNT_W  count of mismatching vectors
err  output  1  sticky flag, set on the first mismatch
first_fail  output  3  {a,b,y} of the first mismatching vector
done  output  1  high in the REPORT state
pass  output  1  valid while done; equals (fail_cnt==0)

Behaviour:
- Reset (asynchronous, immediate) values:
  - state = IDLE
  - in_ready = 0, done = 0, pass = 0, err = 0
  - cov = 0, pass_cnt = 0, fail_cnt = 0, first_fail = 0
- States:
  - IDLE: in_ready = 0. On start, go to CHECK. Clear cov, counters, err and first_fail. Latch func_sel into func_q.
  - CHECK: in_ready = 1. A vector is accepted on a cycle where in_valid and in_ready are both high.
    - Compute exp = f(func_q, a, b).
    - If y == exp, pass_cnt increments; otherwise fail_cnt increments.
    - On a mismatch while err == 0, set err and capture first_fail = {a,b,y}.
    - Set cov[{a,b}].
    - All updates are registered, so they are visible one cycle after acceptance.
    - When the cov value after this update equals 4'b1111, go to REPORT in the same edge.
  - REPORT: in_ready = 0, done = 1, pass = (fail_cnt==0). Hold all statistics until the next start, which reclears and returns to CHECK.
- Repeated combinations are counted every time they occur; cov is unaffected by repeats.
- Counters saturate at all-ones and never wrap. Saturation does not change the pass/fail verdict.
- in_valid while in_ready = 0 is ignored: no count and no coverage update.
- start during CHECK restarts immediately: statistics are cleared and func_q is relatched. Any vector presented in that same cycle is dropped, because start has priority.
- start during IDLE or REPORT behaves as described in the state list above.
- rst asserted mid-check aborts to IDLE and clears all outputs asynchronously. There is no partial report.
- X on y counts as a mismatch. In the RTL, this is implemented as the inequality being true for any non-0/1 value via the (y === exp) check; simulation only.

Decomposition:
- Package gate_chk_pkg:
  - func_e enum {F_AND, F_OR, F_XOR, F_NAND}
  - state_e {S_IDLE, S_CHECK, S_REPORT}
  - constant COV_ALL = 4'b1111
- Sub-module gate_ref_model: combinational, (func, a, b) -> exp. It is reused by the gate benches as the golden model.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset with rst=1 mid-idle, then release -> all outputs 0, in_ready = 0; start with func_sel=1 (OR) -> in_ready = 1 on the next cycle.
- OR, correct DUT: apply {a,b,y} = 000, 011, 101, 111 with in_valid held 1 -> cov goes 0001, 0011, 0111, 1111; pass_cnt = 4; done = 1 and pass = 1 one cycle after the last vector; in_ready = 0.
- OR with a stuck-at-0 output: apply 000, 011(y=0), 101(y=0), 111(y=0) -> fail_cnt = 3, pass_cnt = 1, err = 1, first_fail = 3'b010, done = 1, pass = 0.
- XOR with repeats: apply 000 three times, then 011, 101, 110 -> pass_cnt = 6, cov = 1111 only after 110, done asserts once.
- start pulse mid-CHECK after 2 vectors, with in_valid = 1 in the same cycle -> that vector is dropped, counters and cov = 0, func relatched; the next 4 vectors complete normally.
- Saturation with CNT_W = 2: feed 5 passing 00 vectors, then the remaining 3 combinations -> pass_cnt sticks at 3, done = 1, pass = 1.
